// File: rtl/dma_pkg.sv
// dma_pkg: shared types and constants for the DMA DRAM responder (DRAIN state only with DMA_RD_TIMEOUT_EN).
package dma_pkg;
    localparam int DRAM_AW = 21;
    localparam int DRAM_DW = 16;
    localparam logic [DRAM_DW-1:0] RD_ABORT = 16'hFFFF;
`ifdef DMA_RD_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, DONE, DRAIN} state_e;
`else
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, DONE} state_e;
`endif
endpackage

// File: rtl/dma_dram_responder.sv
// dma_dram_responder: one-word-at-a-time DMA to SDRAM command bridge with Z80 low-priority yield.
// Optional read timeout and sticky dma_rd_err_o port are built with DMA_RD_TIMEOUT_EN.
module dma_dram_responder
    import dma_pkg::*;
#(
    parameter int RD_TIMEOUT = 63
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dma_req_i,
    input  logic               dma_rnw_i,
    input  logic [DRAM_AW-1:0] dma_addr_i,
    input  logic [DRAM_DW-1:0] dma_wrdata_i,
    input  logic               dma_lp_i,
    input  logic               z80_dram_pend_i,
    output logic               dma_next_o,
    output logic [DRAM_DW-1:0] dma_rddata_o,
    output logic               mc_req_o,
    output logic               mc_rnw_o,
    output logic [DRAM_AW-1:0] mc_addr_o,
    output logic [DRAM_DW-1:0] mc_wrdata_o,
    input  logic               mc_ack_i,
    input  logic               mc_rdvld_i,
    input  logic [DRAM_DW-1:0] mc_rddata_i
`ifdef DMA_RD_TIMEOUT_EN
    ,
    output logic               dma_rd_err_o
`endif
);
    state_e state_q, state_d;
    logic cmd_rnw_q;
    logic [DRAM_AW-1:0] cmd_addr_q;
    logic [DRAM_DW-1:0] cmd_wrdata_q, rddata_q;
    logic rd_cap;

    assign mc_req_o     = state_q == ISSUE;
    assign mc_rnw_o     = cmd_rnw_q;
    assign mc_addr_o    = cmd_addr_q;
    assign mc_wrdata_o  = cmd_wrdata_q;
    assign dma_rddata_o = rddata_q;
    // a DMA that dropped its request mid-cycle must not see a strobe
    assign dma_next_o   = state_q == DONE && dma_req_i;
    assign rd_cap       = mc_rdvld_i && (state_q == WAIT_RD || (state_q == ISSUE && mc_ack_i && cmd_rnw_q));

`ifdef DMA_RD_TIMEOUT_EN
    localparam int CW = $clog2(RD_TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    logic aborted_q, err_q, cnt_hit, timeout;

    assign cnt_hit      = cnt_q == CW'(RD_TIMEOUT - 1);
    assign timeout      = state_q == WAIT_RD && !mc_rdvld_i && cnt_hit;
    assign dma_rd_err_o = err_q;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = (dma_req_i && !(dma_lp_i && z80_dram_pend_i)) ? ISSUE : IDLE;
            ISSUE:   state_d = !mc_ack_i ? ISSUE : (cmd_rnw_q && !mc_rdvld_i) ? WAIT_RD : DONE;
`ifdef DMA_RD_TIMEOUT_EN
            WAIT_RD: state_d = (mc_rdvld_i || timeout) ? DONE : WAIT_RD;
            DONE:    state_d = aborted_q ? DRAIN : IDLE;
            // swallow the late beat of an aborted read before accepting new work
            DRAIN:   state_d = (mc_rdvld_i || cnt_hit) ? IDLE : DRAIN;
`else
            WAIT_RD: state_d = mc_rdvld_i ? DONE : WAIT_RD;
            DONE:    state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cmd_rnw_q    <= 1'b1;
            cmd_addr_q   <= '0;
            cmd_wrdata_q <= '0;
            rddata_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == ISSUE) begin
                cmd_rnw_q    <= dma_rnw_i;
                cmd_addr_q   <= dma_addr_i;
                cmd_wrdata_q <= dma_wrdata_i;
            end
            if (rd_cap) rddata_q <= mc_rddata_i;
`ifdef DMA_RD_TIMEOUT_EN
            else if (timeout) rddata_q <= RD_ABORT;
`endif
        end
    end

`ifdef DMA_RD_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cnt_q <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
            if (timeout) begin
                aborted_q <= 1'b1;
                err_q     <= 1'b1;
            end else if (state_q == DONE) aborted_q <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_dma_dram_responder.sv
// tb_dma_dram_responder: transaction-schedule reference model with per-cycle compare plus literal timing pins.
module tb_dma_dram_responder;
    localparam int TO = 8;

    logic clk = 1'b0, reset = 1'b1;
    logic dma_req, dma_rnw, dma_lp, z80_dram_pend, mc_ack, mc_rdvld;
    logic [20:0] dma_addr;
    logic [15:0] dma_wrdata, mc_rddata;
    logic dma_next, mc_req, mc_rnw;
    logic [15:0] dma_rddata, mc_wrdata;
    logic [20:0] mc_addr;
`ifdef DMA_RD_TIMEOUT_EN
    logic dma_rd_err;
`endif

    always #5 clk = ~clk;

    dma_dram_responder #(.RD_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .dma_req_i(dma_req), .dma_rnw_i(dma_rnw), .dma_addr_i(dma_addr), .dma_wrdata_i(dma_wrdata),
        .dma_lp_i(dma_lp), .z80_dram_pend_i(z80_dram_pend),
        .dma_next_o(dma_next), .dma_rddata_o(dma_rddata),
        .mc_req_o(mc_req), .mc_rnw_o(mc_rnw), .mc_addr_o(mc_addr), .mc_wrdata_o(mc_wrdata),
        .mc_ack_i(mc_ack), .mc_rdvld_i(mc_rdvld), .mc_rddata_i(mc_rddata)
`ifdef DMA_RD_TIMEOUT_EN
        , .dma_rd_err_o(dma_rd_err)
`endif
    );

    int cyc = 0, checks = 0, errors = 0;
    int samp = 0, next_cyc = 0, next_cnt = 0, req_cyc = 0;
    logic req_prev = 1'b0;
    bit chk_on = 0;
    logic e_req = 1'b0, e_rnw = 1'b1, e_next = 1'b0, e_err = 1'b0;
    logic [20:0] e_addr = '0;
    logic [15:0] e_wd = '0, e_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, got, exp, cyc);
        end
    endtask

    always @(negedge clk) if (chk_on) begin
        check("mc_req", 32'(mc_req), 32'(e_req));
        check("dma_next", 32'(dma_next), 32'(e_next));
        check("dma_rddata", 32'(dma_rddata), 32'(e_rd));
        check("mc_rnw", 32'(mc_rnw), 32'(e_rnw));
        check("mc_addr", 32'(mc_addr), 32'(e_addr));
        check("mc_wrdata", 32'(mc_wrdata), 32'(e_wd));
`ifdef DMA_RD_TIMEOUT_EN
        check("dma_rd_err", 32'(dma_rd_err), 32'(e_err));
`endif
        if (dma_next) begin
            next_cyc = cyc;
            next_cnt++;
        end
        if (mc_req && !req_prev) req_cyc = cyc;
        req_prev = mc_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One DMA word: y yield cycles, ack after ack_dly extra ISSUE cycles, read data lat cycles after ack.
    task automatic txn(input logic rnw, input logic [20:0] a, input logic [15:0] wd, input logic [15:0] rd,
                       input int y, input logic lp, input int ack_dly, input int lat, input bit wdraw, input int gaps);
        bit tmo;
        tmo = 0;
`ifdef DMA_RD_TIMEOUT_EN
        tmo = rnw && lat > TO;
`endif
        mc_ack = 0; mc_rdvld = 0;
        dma_req = 1; dma_rnw = rnw; dma_addr = a; dma_wrdata = wd; dma_lp = lp; z80_dram_pend = y > 0;
        for (int i = 0; lp && i < y; i++) begin
            tick();
            if (i == y - 1) z80_dram_pend = 0;
        end
        samp = cyc;
        tick();
        e_req = 1; e_rnw = rnw; e_addr = a; e_wd = wd;
        dma_rnw = 1'($urandom); dma_addr = 21'($urandom); dma_wrdata = 16'($urandom);
        dma_lp = 1'($urandom); z80_dram_pend = 1'($urandom);
        for (int i = 0; i < ack_dly; i++) tick();
        mc_ack = 1; mc_rdvld = rnw && lat == 0; mc_rddata = rd;
        tick();
        mc_ack = 0; mc_rdvld = 0; e_req = 0;
        if (wdraw) dma_req = 0;
        if (rnw && lat > 0)
            for (int i = 1; i <= (tmo ? TO : lat); i++) begin
                mc_rdvld = i == lat; mc_rddata = rd;
                tick();
                mc_rdvld = 0;
            end
        e_next = dma_req;
        if (rnw) e_rd = tmo ? 16'hFFFF : rd;
        if (tmo) e_err = 1;
        mc_rdvld = !tmo && 1'($urandom); mc_rddata = 16'($urandom);
        tick();
        e_next = 0; mc_rdvld = 0;
        if (tmo) begin
            dma_req = 0; mc_rdvld = 1;
            tick();
            mc_rdvld = 0;
        end
        for (int g = 0; g < gaps; g++) begin
            dma_req = 0; mc_rdvld = 1'($urandom); mc_rddata = 16'($urandom);
            tick();
        end
        mc_rdvld = 0;
    endtask

    initial begin
        int t0, n0, lat;
        dma_req = 0; dma_rnw = 0; dma_addr = '0; dma_wrdata = '0; dma_lp = 0; z80_dram_pend = 0;
        mc_ack = 0; mc_rdvld = 0; mc_rddata = '0;
        tick();
        chk_on = 1;
        tick();
        reset = 0;
        tick();

        n0 = next_cnt;
        txn(0, 21'h01234, 16'hBEEF, 16'h0, 0, 0, 0, 0, 0, 0);
        check("wr_latency", 32'(next_cyc - samp), 32'd2);
        check("wr_pulses", 32'(next_cnt - n0), 32'd1);
        check("wr_addr_lit", 32'(mc_addr), 32'h01234);
        check("wr_data_lit", 32'(mc_wrdata), 32'hBEEF);

        txn(1, 21'h1FFFFF, 16'h0, 16'hA55A, 0, 0, 0, 3, 0, 1);
        check("rd_latency", 32'(next_cyc - samp), 32'd5);
        check("rd_data_lit", 32'(dma_rddata), 32'hA55A);

        t0 = cyc;
        txn(0, 21'h00777, 16'h1357, 16'h0, 10, 1, 0, 0, 0, 0);
        check("yield_req", 32'(req_cyc - t0), 32'd11);
        t0 = cyc;
        txn(0, 21'h00778, 16'h2468, 16'h0, 10, 0, 0, 0, 0, 0);
        check("noyield_req", 32'(req_cyc - t0), 32'd1);

        n0 = next_cnt;
        txn(1, 21'h0CAFE, 16'h0, 16'h5A5A, 0, 0, 1, 2, 1, 1);
        check("wdraw_pulses", 32'(next_cnt - n0), 32'd0);

        dma_req = 1; dma_rnw = 1; dma_addr = 21'h0ABCD; dma_wrdata = 16'h1111; dma_lp = 0; z80_dram_pend = 0;
        tick();
        e_req = 1; e_rnw = 1; e_addr = 21'h0ABCD; e_wd = 16'h1111; mc_ack = 1;
        tick();
        mc_ack = 0; e_req = 0; reset = 1;
        tick();
        reset = 0; dma_req = 0; e_rnw = 1; e_addr = '0; e_wd = '0; e_rd = '0; e_err = 0;
        mc_rdvld = 1; mc_rddata = 16'hDEAD;
        tick();
        mc_rdvld = 0;
        check("rst_stray_rddata", 32'(dma_rddata), 32'h0);

`ifdef DMA_RD_TIMEOUT_EN
        txn(1, 21'h00042, 16'h0, 16'h0, 0, 0, 0, 100, 0, 1);
        check("to_latency", 32'(next_cyc - samp), 32'(2 + TO));
        check("to_rddata_lit", 32'(dma_rddata), 32'hFFFF);
        check("to_err_lit", 32'(dma_rd_err), 32'd1);
`endif

        for (int n = 0; n < 200; n++) begin
            lat = $urandom_range(4);
`ifdef DMA_RD_TIMEOUT_EN
            if ($urandom_range(9) == 0) lat = 100;
`endif
            txn(1'($urandom), 21'($urandom), 16'($urandom), 16'($urandom), $urandom_range(3), 1'($urandom),
                $urandom_range(2), lat, $urandom_range(7) == 0, $urandom_range(2));
        end

        reset = 1;
        tick();
        reset = 0; e_rnw = 1; e_addr = '0; e_wd = '0; e_rd = '0; e_err = 0; e_next = 0; e_req = 0;
        tick();
`ifdef DMA_RD_TIMEOUT_EN
        check("err_cleared", 32'(dma_rd_err), 32'd0);
`endif
        check("end_mc_rnw", 32'(mc_rnw), 32'd1);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
